// File: rtl/aib_tx_arbiter.sv
// ---------------------------------------------------------------------------
// aib_tx_arbiter
//
// Transmit arbiter sitting directly upstream of the AIB channel's 72-bit Tx
// datapath. Merges up to four 64-bit packet streams into one flit stream with
// packet-granular round-robin arbitration. Every flit carries the source ID,
// an end-of-packet flag and a per-source 5-bit packet sequence number. A
// 2-entry skid buffer sits between the arbiter and the Tx interface, so the
// channel-facing outputs come straight from registers.
//
// Flit layout: [71:70] source ID, [69] last, [68:64] seq, [63:0] data.
//
// Ports
//   i_bus_clk    in   1            bus clock (channel Tx bus-side clock)
//   i_rst        in   1            asynchronous active-high reset
//   c_src_en     in   NUM_SRC      per-source arbitration enable (quasi-static)
//   i_src_valid  in   NUM_SRC      per-source beat valid
//   o_src_ready  out  NUM_SRC      per-source beat ready
//   i_src_data   in   NUM_SRC x 64 per-source payload
//   i_src_last   in   NUM_SRC      last beat of a packet
//   o_tx_valid   out  1            flit valid towards the channel
//   i_tx_ready   in   1            flit ready from the channel
//   o_tx_data    out  72           flit towards the channel
//   o_busy       out  1            packet in progress or flits buffered
//
// NUM_SRC must lie in 2..4 because the ID field is two bits wide.
// ---------------------------------------------------------------------------
module aib_tx_arbiter #(
   parameter int NUM_SRC = 4
) (
   input  logic                     i_bus_clk,
   input  logic                     i_rst,
   input  logic [NUM_SRC-1:0]       c_src_en,
   input  logic [NUM_SRC-1:0]       i_src_valid,
   output logic [NUM_SRC-1:0]       o_src_ready,
   input  logic [NUM_SRC-1:0][63:0] i_src_data,
   input  logic [NUM_SRC-1:0]       i_src_last,
   output logic                     o_tx_valid,
   input  logic                     i_tx_ready,
   output logic [71:0]              o_tx_data,
   output logic                     o_busy
);

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   localparam logic [1:0] LAST_ID   = 2'(NUM_SRC - 1);
   localparam logic [2:0] SRC_COUNT = 3'(NUM_SRC);

   state_t      state;
   state_t      state_next;

   logic [1:0]  owner;
   logic [1:0]  rr_ptr;
   logic [4:0]  seq [NUM_SRC];

   logic [71:0] buf_mem [2];
   logic        wr_ptr;
   logic        rd_ptr;
   logic [1:0]  count;

   logic        space;
   logic        found;
   logic [1:0]  candidate;
   logic [2:0]  scan;
   logic [1:0]  sel;
   logic        accept;
   logic        sel_last;
   logic        pop;
   logic [71:0] flit;

   // A new beat can only be taken while the skid buffer has a free slot;
   // a pop in the same cycle does not count, which keeps ready registered-ish
   // and gives the one-cycle ready gap after backpressure release.
   assign space = (count < 2'd2);
   assign pop   = (count != 2'd0) & i_tx_ready;

   // Round-robin candidate search: walk upward from rr_ptr, wrapping at
   // NUM_SRC, and take the first enabled source that is presenting a beat.
   always_comb begin
      found     = 1'b0;
      candidate = 2'd0;
      scan      = 3'd0;
      for (int i = 0; i < NUM_SRC; i++) begin
         scan = {1'b0, rr_ptr} + 3'(i);
         if (scan >= SRC_COUNT) begin
            scan = scan - SRC_COUNT;
         end
         if (!found && i_src_valid[scan[1:0]] && c_src_en[scan[1:0]]) begin
            found     = 1'b1;
            candidate = scan[1:0];
         end
      end
   end

   // While a packet is in flight the owner keeps the grant and the enables
   // are ignored, so a packet that has started always completes.
   assign sel      = (state == LOCKED) ? owner : candidate;
   assign sel_last = i_src_last[sel];
   assign accept   = i_src_valid[sel] & o_src_ready[sel];
   assign flit     = {sel, sel_last, seq[sel], i_src_data[sel]};

   // FSM state register.
   always_ff @(posedge i_bus_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // FSM next state: a single-beat packet never leaves IDLE, a multi-beat
   // packet locks on its first beat and unlocks on its last one.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept && !sel_last) begin
               state_next = LOCKED;
            end
         end
         LOCKED: begin
            if (accept && sel_last) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // FSM outputs: exactly one source may see ready, and only while there is
   // buffer space. Ready is forced low while reset is held.
   always_comb begin
      o_src_ready = '0;
      if (!i_rst && space && ((state == LOCKED) || found)) begin
         o_src_ready[sel] = 1'b1;
      end
   end

   // Owner capture and round-robin pointer. The pointer only moves at packet
   // boundaries, which is what makes arbitration packet-granular.
   always_ff @(posedge i_bus_clk or posedge i_rst) begin
      if (i_rst) begin
         owner  <= 2'd0;
         rr_ptr <= 2'd0;
      end else begin
         if ((state == IDLE) && accept && !sel_last) begin
            owner <= candidate;
         end
         if (accept && sel_last) begin
            rr_ptr <= (sel == LAST_ID) ? 2'd0 : sel + 2'd1;
         end
      end
   end

   // Per-source packet sequence numbers; bumped once the last beat of a
   // packet is taken so every beat of one packet carries the same value.
   always_ff @(posedge i_bus_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int k = 0; k < NUM_SRC; k++) begin
            seq[k] <= 5'd0;
         end
      end else if (accept && sel_last) begin
         seq[sel] <= seq[sel] + 5'd1;
      end
   end

   // Two-entry skid buffer in FIFO order. Reset clears the storage too so
   // the flit output reads zero and nothing from before reset can reappear.
   always_ff @(posedge i_bus_clk or posedge i_rst) begin
      if (i_rst) begin
         buf_mem[0] <= '0;
         buf_mem[1] <= '0;
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         count      <= 2'd0;
      end else begin
         if (accept) begin
            buf_mem[wr_ptr] <= flit;
            wr_ptr          <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({accept, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   assign o_tx_valid = (count != 2'd0);
   assign o_tx_data  = buf_mem[rd_ptr];
   assign o_busy     = (state == LOCKED) | (count != 2'd0);

endmodule

// File: doc/aib_tx_arbiter.md
# aib_tx_arbiter

Bus-side transmit arbiter that sits directly upstream of the AIB channel's 72-bit Tx datapath (`i_tx_valid` / `o_tx_ready` / `i_tx_data`). It merges up to four 64-bit packet streams into a single flit stream, with packet-granular round-robin arbitration. Each outgoing flit carries a source ID, an end-of-packet flag and a per-source packet sequence number. A 2-entry output skid buffer makes the output registered.

## Interface
- `NUM_SRC`, default 4: number of source streams; legal range 2..4, because the ID field is 2 bits.
- `i_bus_clk`  in  1  bus clock; same clock as the channel's Tx bus side.
- `i_rst`  in  1  reset; asynchronous, active-high.
- `c_src_en`  in  NUM_SRC  per-source arbitration enable; quasi-static.
- `i_src_valid`  in  NUM_SRC  per-source beat valid.
- `o_src_ready`  out  NUM_SRC  per-source beat ready.
- `i_src_data`  in  NUM_SRC x 64  per-source payload, packed `[NUM_SRC-1:0][63:0]`.
- `i_src_last`  in  NUM_SRC  marks the last beat of a packet.
- `o_tx_valid`  out  1  flit valid; connects to the channel's `i_tx_valid`.
- `i_tx_ready`  in  1  flit ready; driven by the channel's `o_tx_ready`.
- `o_tx_data`  out  72  flit; connects to the channel's `i_tx_data`.
- `o_busy`  out  1  high when the FSM is in LOCKED or the buffer is non-empty.

## Operation
- **Flit format:**
  - `[71:70]` source ID
  - `[69]` last
  - `[68:64]` seq
  - `[63:0]` data
- **seq:** per-source 5-bit packet counter, stamped on every beat of a packet.
  - Increments after that source's `last` beat is accepted.
  - Wraps 31 -> 0.
- **Beat acceptance:** a beat is accepted from source k when `i_src_valid[k] & o_src_ready[k]`.
- **space** = buffer count < 2.
- **FSM states:** IDLE and LOCKED(owner).
- **IDLE:**
  - The candidate is the first k with `i_src_valid[k] & c_src_en[k]`, searching upward from `rr_ptr` with wrap.
  - `o_src_ready[candidate] = space`; all other ready bits are 0.
  - If the beat is accepted and `last=0`: go to LOCKED(candidate).
  - If the beat is accepted and `last=1`: stay in IDLE and set `rr_ptr = candidate+1` (mod NUM_SRC).
- **LOCKED(owner):**
  - `o_src_ready[owner] = space`; all other ready bits are 0.
  - `c_src_en` is ignored, so a packet in progress always completes.
  - On acceptance of a `last` beat: go to IDLE and set `rr_ptr = owner+1` (mod NUM_SRC).
  - An owner valid gap (valid low mid-packet) holds LOCKED indefinitely.
- **Ready/valid dependency:** `o_src_ready` may depend combinationally on `i_src_valid`. Sources must not drop `valid` or change data/last while `valid & !ready`.
- **Skid buffer:** 2 entries, FIFO order.
  - Push = accepted beat. Pop = `o_tx_valid & i_tx_ready`.
  - Push and pop in the same cycle leave the count unchanged.
  - No push when full. No pop when empty.
- **Output:** `o_tx_valid = (count != 0)`. `o_tx_data` is the head entry and is held stable while `o_tx_valid & !i_tx_ready`.
- **Out-of-range sources:** source indices >= NUM_SRC do not exist, and `rr_ptr` arithmetic is mod NUM_SRC.

## Timing
- **Reset values:** while `i_rst` is high the block is held in reset, with:
  - `o_tx_valid=0`, `o_tx_data=0`, `o_src_ready=0`, `o_busy=0`
  - FSM in IDLE, `rr_ptr=0`, all seq=0, buffer count=0
- **Reset mid-packet:** a partial packet is dropped. The next flit after reset starts a fresh arbitration with seq 0.
- **Latency:** a beat accepted in cycle N appears on `o_tx_data` in cycle N+1 if the buffer was empty. Otherwise it appears behind the older entries.
- **Throughput:** 1 beat/cycle sustained while `i_tx_ready=1`.
- **Switching sources:** no bubble. The `last` beat of packet A and the first beat of packet B (another source) are accepted in consecutive cycles.
- **Backpressure release:**
  - With `i_tx_ready=0`, two beats are accepted, then `o_src_ready` drops.
  - The first cycle with `i_tx_ready=1` pops one entry. `o_src_ready` reasserts in the following cycle.

## Test plan
- **Reset state:** assert `i_rst` for 3 cycles with all sources valid.
  - During reset: all outputs are 0.
  - First cycle after release: source 0 is granted.
  - Next cycle: flit `{2'd0,last,5'd0,data}` appears.
- **Round-robin order:** all 4 sources continuously send 2-beat packets, `i_tx_ready=1`.
  - Flit IDs run 0,0,1,1,2,2,3,3,0,0,…
  - No idle cycles.
  - The seq of source 2 reads 0 on its first packet and 1 on its second.
- **Lock and enable:** source 1 sends a 5-beat packet; clear `c_src_en[1]` after beat 2.
  - All 5 beats are sent contiguously with ID 1.
  - Source 1 is not granted again until `c_src_en[1]` is set.
- **Backpressure:** hold `i_tx_ready=0` for 10 cycles while source 3 streams.
  - Exactly 2 beats are accepted.
  - `o_tx_data` stays stable.
  - After release, beats emerge in order with no loss or duplication.
- **Seq wrap:** source 0 sends 33 single-beat packets.
  - Seq runs 0..31, 0.
  - `rr_ptr` advances, so interleaved source-1 packets alternate with source-0 packets.
- **Reset mid-packet:** assert `i_rst` after beat 2 of a 4-beat packet, with 2 flits buffered.
  - The buffer is flushed and `o_tx_valid` goes to 0 immediately.
  - After release, seq restarts at 0 and no stale flit is emitted.
